// File: rtl/data_rsp_pkg.sv
// Shared constants for the data BRAM request/response pair, so data_req and data_rsp agree on
// widths and BRAM read latency.
package data_rsp_pkg;

    localparam int unsigned DRSP_DATA_WIDTH        = 32;
    localparam int unsigned DRSP_REG_WIDTH         = 32;
    localparam int unsigned DRSP_KERNEL_SIZE_WIDTH = 2;
    localparam int unsigned DRSP_RD_LATENCY        = 2;
    localparam int unsigned DRSP_DEPTH             = 8;
    localparam int unsigned DRSP_PTR_WIDTH         = 3;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt += 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only alongside a pop,
// pop while empty is ignored. Synchronous clear empties it.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [$clog2(DEPTH):0]   occ,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]         occ_q, occ_d;
    logic                  push_en, pop_en;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == (PtrW + 1)'(DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign rdata   = mem_q[rd_ptr_q];
    assign occ     = occ_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push_en && !pop_en)      occ_d = occ_q + (PtrW + 1)'(1);
            else if (pop_en && !push_en) occ_d = occ_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_en && !clr) mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/data_rsp.sv
// Read-response side of the data BRAM interface: captures read data after a fixed latency,
// buffers it, tags row/window boundaries and stalls the requester before the FIFO can overrun.
module data_rsp
    import data_rsp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = DRSP_DATA_WIDTH,
    parameter int unsigned DEPTH             = DRSP_DEPTH,
    parameter int unsigned PTR_WIDTH         = DRSP_PTR_WIDTH,
    parameter int unsigned RD_LATENCY        = DRSP_RD_LATENCY,
    parameter int unsigned REG_WIDTH         = DRSP_REG_WIDTH,
    parameter int unsigned KERNEL_SIZE_WIDTH = DRSP_KERNEL_SIZE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_rden,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_row_last,
    output logic                  o_win_last,
    input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
    input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
    output logic                  o_err_ovf,
    output logic [REG_WIDTH-1:0]  dbg_datarsp_occ,
    output logic [REG_WIDTH-1:0]  dbg_datarsp_inflt
);

    localparam int unsigned OccW = PTR_WIDTH + 1;
    localparam int unsigned SumW = PTR_WIDTH + 2;

    logic [RD_LATENCY-1:0]        vld_pipe_q, vld_pipe_d;
    logic                         push, pop, fifo_full, fifo_empty;
    logic [OccW-1:0]              occ, inflight;
    logic [SumW-1:0]              pending;
    logic [7:0]                   word_cnt_q, word_cnt_d, row_w;
    logic [KERNEL_SIZE_WIDTH-1:0] line_cnt_q, line_cnt_d, k_last;
    logic                         err_ovf_q, err_ovf_d;
    logic                         unused_conf;

    assign unused_conf = ^{i_conf_inputshape[REG_WIDTH-1:8],
                           i_conf_kernelshape[REG_WIDTH-1:KERNEL_SIZE_WIDTH]};

    assign row_w  = i_conf_inputshape[7:0];
    assign k_last = i_conf_kernelshape[KERNEL_SIZE_WIDTH-1:0] - KERNEL_SIZE_WIDTH'(1);

    assign push     = vld_pipe_q[RD_LATENCY-1];
    assign o_valid  = ~fifo_empty;
    assign pop      = o_valid & i_ready;
    assign inflight = OccW'(popcount(32'(vld_pipe_q)));

    // Reserve room for words already requested so a late response can never overflow.
    assign pending = SumW'(occ) + SumW'(inflight);
    assign o_stall = (pending >= SumW'(DEPTH));

    assign o_row_last        = o_valid & (word_cnt_q == row_w);
    assign o_win_last        = o_row_last & (line_cnt_q == k_last);
    assign o_err_ovf         = err_ovf_q;
    assign dbg_datarsp_occ   = REG_WIDTH'(occ);
    assign dbg_datarsp_inflt = REG_WIDTH'(inflight);

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_clr),
        .push  (push),
        .wdata (i_rdata),
        .pop   (pop),
        .rdata (o_data),
        .occ   (occ),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        vld_pipe_d = RD_LATENCY'({vld_pipe_q, i_rden});
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        err_ovf_d  = err_ovf_q | (push & fifo_full & ~pop);
        if (pop) begin
            if (word_cnt_q == row_w) begin
                word_cnt_d = '0;
                line_cnt_d = (line_cnt_q == k_last) ? '0 : line_cnt_q + KERNEL_SIZE_WIDTH'(1);
            end else begin
                word_cnt_d = word_cnt_q + 8'd1;
            end
        end
        if (i_clr) begin
            vld_pipe_d = '0;
            word_cnt_d = '0;
            line_cnt_d = '0;
            err_ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            err_ovf_q  <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

endmodule
